// File: rtl/eth_rx_frame_admit_ctrl.sv
// eth_rx_frame_admit_ctrl: write-side admission control for the RX frame queue.
// Beats from a non-back-pressurable MAC stream are written to the queue in the
// cycle they arrive. A clean frame is committed with q_confirm. A frame that
// errors, overflows the queue or runs too long is rolled back with q_erase, and
// its remaining beats are discarded.
// Optional build macro: ETH_RX_ADMIT_RUNT_FILTER_EN erases single-beat frames.
module eth_rx_frame_admit_ctrl #(
    parameter int DATA_W    = 512,
    parameter int KEEP_W    = DATA_W/8,
    parameter int MAX_BEATS = 190,
    parameter int CNT_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          s_tdata,
    input  logic [KEEP_W-1:0]          s_tkeep,
    input  logic                       s_tvalid,
    input  logic                       s_tlast,
    input  logic                       s_tuser,
    output logic [DATA_W+KEEP_W:0]     q_din,
    output logic                       q_write,
    output logic                       q_confirm,
    output logic                       q_erase,
    input  logic                       q_full,
    output logic [CNT_W-1:0]           frames_ok,
    output logic [CNT_W-1:0]           frames_drop,
    output logic                       busy
);

    localparam int BCW = $clog2(MAX_BEATS+1);
    localparam logic [BCW-1:0] MAX_CNT = BCW'(MAX_BEATS);

`ifdef ETH_RX_ADMIT_RUNT_FILTER_EN
    localparam bit RUNT_EN = 1'b1;
`else
    localparam bit RUNT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, STORE, DROP} state_t;

    state_t         state, state_nxt;
    logic [BCW-1:0] beat_cnt, cnt_nxt;
    logic           inc_ok, inc_drop;
    logic           bad_end;

    // Queue word is the raw beat; no data latency.
    assign q_din = {s_tlast, s_tkeep, s_tdata};
    assign busy  = (state != IDLE);

    // A written last beat is bad if flagged by the MAC or, when filtering, too short.
    assign bad_end = s_tuser || (RUNT_EN && (cnt_nxt < BCW'(2)));

    // Next-state, queue strobes and counter increments.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = beat_cnt;
        q_write   = 1'b0;
        q_confirm = 1'b0;
        q_erase   = 1'b0;
        inc_ok    = 1'b0;
        inc_drop  = 1'b0;
        if (!rst && s_tvalid) begin
            unique case (state)
                IDLE: begin
                    if (q_full) begin
                        // Nothing written yet, so nothing to roll back.
                        inc_drop = 1'b1;
                        if (!s_tlast) state_nxt = DROP;
                    end else begin
                        q_write = 1'b1;
                        cnt_nxt = BCW'(1);
                        if (s_tlast) begin
                            if (bad_end) begin
                                q_erase  = 1'b1;
                                inc_drop = 1'b1;
                            end else begin
                                q_confirm = 1'b1;
                                inc_ok    = 1'b1;
                            end
                        end else begin
                            state_nxt = STORE;
                        end
                    end
                end
                STORE: begin
                    if (q_full || beat_cnt == MAX_CNT) begin
                        q_erase   = 1'b1;
                        inc_drop  = 1'b1;
                        state_nxt = s_tlast ? IDLE : DROP;
                    end else begin
                        q_write = 1'b1;
                        cnt_nxt = beat_cnt + 1'b1;
                        if (s_tlast) begin
                            state_nxt = IDLE;
                            if (bad_end) begin
                                q_erase  = 1'b1;
                                inc_drop = 1'b1;
                            end else begin
                                q_confirm = 1'b1;
                                inc_ok    = 1'b1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (s_tlast) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, beat count and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            frames_ok   <= '0;
            frames_drop <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= cnt_nxt;
            if (inc_ok)   frames_ok   <= frames_ok + CNT_W'(1);
            if (inc_drop) frames_drop <= frames_drop + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_admit_ctrl.sv
// Directed bench for eth_rx_frame_admit_ctrl with MAX_BEATS=4 and a 32-bit beat.
// Builds with or without ETH_RX_ADMIT_RUNT_FILTER_EN.
module tb_eth_rx_frame_admit_ctrl;

    localparam int DATA_W    = 32;
    localparam int KEEP_W    = DATA_W/8;
    localparam int MAX_BEATS = 4;
    localparam int CNT_W     = 32;

`ifdef ETH_RX_ADMIT_RUNT_FILTER_EN
    localparam bit RUNT = 1'b1;
`else
    localparam bit RUNT = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [DATA_W-1:0]      s_tdata;
    logic [KEEP_W-1:0]      s_tkeep;
    logic                   s_tvalid, s_tlast, s_tuser;
    logic [DATA_W+KEEP_W:0] q_din;
    logic                   q_write, q_confirm, q_erase, q_full;
    logic [CNT_W-1:0]       frames_ok, frames_drop;
    logic                   busy;

    int nchk = 0;
    int nerr = 0;

    eth_rx_frame_admit_ctrl #(
        .DATA_W(DATA_W), .KEEP_W(KEEP_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .q_din(q_din), .q_write(q_write), .q_confirm(q_confirm), .q_erase(q_erase),
        .q_full(q_full),
        .frames_ok(frames_ok), .frames_drop(frames_drop), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One beat: drive after negedge, check strobes mid-cycle, clock it in, release valid.
    task automatic beat(input string tag, input logic v, input logic l, input logic u,
                        input logic f, input logic ew, input logic ec, input logic ee);
        logic [DATA_W+KEEP_W:0] word;
        @(negedge clk);
        s_tvalid = v; s_tlast = l; s_tuser = u; q_full = f;
        s_tdata  = $urandom;
        s_tkeep  = l ? 4'h3 : 4'hf;
        #1;
        chk({tag, ".wr"}, 64'(q_write), 64'(ew));
        chk({tag, ".cf"}, 64'(q_confirm), 64'(ec));
        chk({tag, ".er"}, 64'(q_erase), 64'(ee));
        if (ew) begin
            word = {l, s_tkeep, s_tdata};
            chk({tag, ".din"}, 64'(q_din), 64'(word));
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; q_full = 1'b0;
    endtask

    task automatic cnts(input string tag, input int ok, input int drop, input logic bsy);
        chk({tag, ".ok"}, 64'(frames_ok), 64'(ok));
        chk({tag, ".drop"}, 64'(frames_drop), 64'(drop));
        chk({tag, ".busy"}, 64'(busy), 64'(bsy));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; s_tvalid = 1'b1; s_tlast = 1'b0; s_tuser = 1'b0; q_full = 1'b0;
        #1;
        chk({tag, ".wr"}, 64'(q_write), 64'd0);
        chk({tag, ".cf"}, 64'(q_confirm), 64'd0);
        chk({tag, ".er"}, 64'(q_erase), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; s_tvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0;
        s_tlast = 1'b0; s_tuser = 1'b0; q_full = 1'b0;

        do_reset("rst0");
        cnts("rst0", 0, 0, 1'b0);

        // 3-beat good frame; tuser on a non-last beat is ignored.
        beat("t1b1", 1, 0, 1, 0, 1, 0, 0);
        chk("t1.busy_mid", 64'(busy), 64'd1);
        beat("t1b2", 1, 0, 0, 0, 1, 0, 0);
        beat("t1b3", 1, 1, 0, 0, 1, 1, 0);
        cnts("t1", 1, 0, 1'b0);

        // 4-beat frame with error on the last beat, then a good 2-beat frame.
        beat("t2b1", 1, 0, 0, 0, 1, 0, 0);
        beat("t2b2", 1, 0, 0, 0, 1, 0, 0);
        beat("t2b3", 1, 0, 0, 0, 1, 0, 0);
        beat("t2b4", 1, 1, 1, 0, 1, 0, 1);
        cnts("t2a", 1, 1, 1'b0);
        beat("t2c1", 1, 0, 0, 0, 1, 0, 0);
        beat("t2c2", 1, 1, 0, 0, 1, 1, 0);
        cnts("t2c", 2, 1, 1'b0);

        // Queue full at beat 2 of 5; the rest is discarded; a stalled cycle in DROP.
        beat("t3b1", 1, 0, 0, 0, 1, 0, 0);
        beat("t3b2", 1, 0, 0, 1, 0, 0, 1);
        cnts("t3m", 2, 2, 1'b1);
        beat("t3b3", 1, 0, 0, 1, 0, 0, 0);
        beat("t3gap", 0, 0, 0, 0, 0, 0, 0);
        beat("t3b4", 1, 0, 0, 0, 0, 0, 0);
        chk("t3.busy4", 64'(busy), 64'd1);
        beat("t3b5", 1, 1, 1, 0, 0, 0, 0);
        cnts("t3", 2, 2, 1'b0);

        // 6-beat frame against MAX_BEATS=4: erase on beat 5, beat 6 dropped.
        beat("t4b1", 1, 0, 0, 0, 1, 0, 0);
        beat("t4b2", 1, 0, 0, 0, 1, 0, 0);
        beat("t4b3", 1, 0, 0, 0, 1, 0, 0);
        beat("t4b4", 1, 0, 0, 0, 1, 0, 0);
        beat("t4b5", 1, 0, 0, 0, 0, 0, 1);
        cnts("t4m", 2, 3, 1'b1);
        beat("t4b6", 1, 1, 0, 0, 0, 0, 0);
        cnts("t4", 2, 3, 1'b0);

        // Exactly MAX_BEATS beats is still a legal frame.
        beat("t8b1", 1, 0, 0, 0, 1, 0, 0);
        beat("t8b2", 1, 0, 0, 0, 1, 0, 0);
        beat("t8b3", 1, 0, 0, 0, 1, 0, 0);
        beat("t8b4", 1, 1, 0, 0, 1, 1, 0);
        cnts("t8", 3, 3, 1'b0);

        // Single-beat frame while the queue is full: no write, dropped, stays idle.
        beat("t6b1", 1, 1, 0, 1, 0, 0, 0);
        cnts("t6", 3, 4, 1'b0);

        // Ten single-beat frames, gaps after every other one.
        for (int i = 0; i < 10; i++) begin
            beat($sformatf("t5f%0d", i), 1, 1, 0, 0, 1, !RUNT, RUNT);
            if (i % 2 == 1) beat($sformatf("t5g%0d", i), 0, 0, 0, 0, 0, 0, 0);
        end
        if (RUNT) cnts("t5", 3, 14, 1'b0);
        else      cnts("t5", 13, 4, 1'b0);

        // Reset in the middle of a frame; the following frame commits normally.
        beat("t7b1", 1, 0, 0, 0, 1, 0, 0);
        do_reset("t7rst");
        cnts("t7r", 0, 0, 1'b0);
        beat("t7c1", 1, 0, 0, 0, 1, 0, 0);
        beat("t7c2", 1, 1, 0, 0, 1, 1, 0);
        cnts("t7", 1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
